div_share_sched: RTL

Round-robin scheduler that shares one pipelined, fixed-latency unsigned divider among `NREQ` requesters in the PAM receiver datapath. It owns the issue side of the divider, grants one request per cycle, and tags each operation with its requester ID. It realigns the tag with the divider's result and returns quotient/remainder on a shared response bus. It also substitutes a defined result for divide-by-zero and flags pipeline misalignment.

---
 rtl/div_share_sched_if.sv | 49 ++++
 rtl/div_share_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_share_sched_if.sv
// Bundles the requester, divider-issue and response signals of div_share_sched.
// The scheduler takes the master view; the surrounding datapath takes the slave view.
interface div_share_sched_if #(
    parameter int NREQ = 4,
    parameter int WD   = 5,
    parameter int WS   = 3
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ*WD-1:0]   req_dividend;
    logic [NREQ*WS-1:0]   req_divisor;
    logic [NREQ-1:0]      gnt;

    logic                 div_en;
    logic [WD-1:0]        div_dividend;
    logic [WS-1:0]        div_divisor;
    logic                 div_rdy;
    logic [WD-1:0]        div_result;
    logic [WS-1:0]        div_remainder;

    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [WD-1:0]        rsp_quot;
    logic [WS-1:0]        rsp_rem;
    logic                 rsp_dbz;

    logic                 busy;
    logic                 sync_err;

    modport master (
        input  hold, req, req_dividend, req_divisor,
        input  div_rdy, div_result, div_remainder,
        output gnt,
        output div_en, div_dividend, div_divisor,
        output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz,
        output busy, sync_err
    );

    modport slave (
        output hold, req, req_dividend, req_divisor,
        output div_rdy, div_result, div_remainder,
        input  gnt,
        input  div_en, div_dividend, div_divisor,
        input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz,
        input  busy, sync_err
    );
endinterface

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined divider among NREQ requesters;
// tags each issue with its requester, realigns the tag with the result and patches divide-by-zero.
module div_share_sched #(
    parameter int NREQ = 4,
    parameter int WD   = 5,
    parameter int WS   = 3,
    parameter int LAT  = 5
) (
    input logic               clk,
    input logic               arst_n,
    div_share_sched_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW  = IDW + 1;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           dbz;
    } tag_t;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic [SW-1:0]  scan_idx;
    logic [WD-1:0]  sel_dividend;
    logic [WS-1:0]  sel_divisor;

    logic           div_en_q, div_en_d;
    logic [WD-1:0]  dividend_q, dividend_d;
    logic [WS-1:0]  divisor_q, divisor_d;
    logic [IDW-1:0] iss_id_q, iss_id_d;
    logic           iss_dbz_q, iss_dbz_d;

    tag_t           tag_q [LAT];
    tag_t           tag_d [LAT];
    tag_t           pop;

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [WD-1:0]  rsp_quot_q, rsp_quot_d;
    logic [WS-1:0]  rsp_rem_q, rsp_rem_d;
    logic           rsp_dbz_q, rsp_dbz_d;
    logic           sync_err_q, sync_err_d;
    logic           any_busy;

    // Scan from ptr upwards with wrap; scan_idx is one bit wider so non-power-of-two NREQ wraps cleanly.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        if (!bus.hold) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = {1'b0, ptr_q} + SW'(k);
                if (scan_idx >= SW'(NREQ)) begin
                    scan_idx = scan_idx - SW'(NREQ);
                end
                if (!gnt_any && bus.req[scan_idx[IDW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx[IDW-1:0];
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_dividend = sel_dividend | bus.req_dividend[i*WD +: WD];
                sel_divisor  = sel_divisor  | bus.req_divisor[i*WS +: WS];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        div_en_d   = gnt_any;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        iss_id_d   = gnt_idx;
        iss_dbz_d  = (sel_divisor == '0);
        if (gnt_any) begin
            dividend_d = sel_dividend;
            divisor_d  = sel_divisor;
            ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    // The tag enters alongside the registered div_en so its last stage lines up with div_rdy.
    always_comb begin
        tag_d[0].valid = div_en_q;
        tag_d[0].id    = iss_id_q;
        tag_d[0].dbz   = iss_dbz_q;
        for (int s = 1; s < LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    assign pop = tag_q[LAT-1];

    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_quot_d  = rsp_quot_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_dbz_d   = rsp_dbz_q;
        sync_err_d  = sync_err_q;
        if (pop.valid && bus.div_rdy) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = pop.id;
            if (pop.dbz) begin
                rsp_quot_d = '1;
                rsp_rem_d  = '0;
                rsp_dbz_d  = 1'b1;
            end else begin
                rsp_quot_d = bus.div_result;
                rsp_rem_d  = bus.div_remainder;
                rsp_dbz_d  = 1'b0;
            end
        end else if (pop.valid != bus.div_rdy) begin
            sync_err_d = 1'b1;
        end
    end

    always_comb begin
        any_busy = div_en_q | rsp_valid_q;
        for (int s = 0; s < LAT; s++) begin
            any_busy = any_busy | tag_q[s].valid;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q       <= '0;
            div_en_q    <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            iss_id_q    <= '0;
            iss_dbz_q   <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            div_en_q    <= div_en_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            iss_id_q    <= iss_id_d;
            iss_dbz_q   <= iss_dbz_d;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dbz_q   <= rsp_dbz_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.gnt          = gnt;
    assign bus.div_en       = div_en_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_quot     = rsp_quot_q;
    assign bus.rsp_rem      = rsp_rem_q;
    assign bus.rsp_dbz      = rsp_dbz_q;
    assign bus.busy         = any_busy;
    assign bus.sync_err     = sync_err_q;
endmodule
